checkers_move_engine: RTL and testbench

- Parametrised checkers rules engine: holds an N x N board (N = 2**CW), arbitrates turns, validates pick/drop selections, executes step and capture moves, and promotes kings.
- Tracks per-colour piece counts and flags game over.
- Sits between the cursor/input controller (sel_valid/sel_loc) and the VGA renderer (serialized_board, legal_move, turn_red).

---
 rtl/checkers_move_engine.sv | 251 +++++++++++++++++++++++++
 tb/tb_checkers_move_engine.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/checkers_move_engine.sv
// Checkers rules engine: N x N board, turn arbitration, pick/drop validation, step/capture, kinging.
// Optional CHECKERS_MULTI_JUMP_EN: after a non-promoting capture the mover keeps the turn while a further jump exists.
module checkers_move_engine #(
    parameter int CW        = 3,
    parameter int INIT_ROWS = 3,
    parameter int CNT_W     = 6
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sel_valid,
    input  logic [2*CW-1:0]                sel_loc,
    output logic [3*(2**CW)*(2**CW)-1:0]   serialized_board,
    output logic [4*(2*CW+1)-1:0]          legal_move,
    output logic                           turn_red,
    output logic                           busy,
    output logic                           move_done,
    output logic                           move_reject,
    output logic [CNT_W-1:0]               red_cnt,
    output logic [CNT_W-1:0]               white_cnt,
    output logic                           game_over,
    output logic                           winner_red
);
    // state     | meaning
    // S_IDLE    | waiting for the mover to pick one of its own pieces
    // S_PICKED  | piece held at src_loc; waiting for a legal destination or deselect
    // S_WR_DST  | copy src piece to dst, kinging on the far row
    // S_CLR_CAP | remove the jumped piece and decrement the opponent count
    // S_CLR_SRC | clear the source square
    // S_DONE    | move committed; hand over the turn or finish the game
    // S_OVER    | game finished, all selections ignored
    typedef enum logic [2:0] {
        S_IDLE, S_PICKED, S_WR_DST, S_CLR_CAP, S_CLR_SRC, S_DONE, S_OVER
    } state_t;

    localparam int N  = 2**CW;
    localparam int NC = N*N;
    localparam int LW = 2*CW;
    localparam int SW = 2*CW+1;
    localparam logic [CW:0]      ONE      = (CW+1)'(1);
    localparam logic [CW-1:0]    Y_TOP    = CW'(N-1);
    localparam logic [CNT_W-1:0] INIT_CNT = CNT_W'(INIT_ROWS*N/2);

    state_t           state, state_nx;
    logic [2:0]       board [NC];
    logic [LW-1:0]    src_loc, dst_loc, mid_loc, calc_loc, hit_mid;
    logic [CW-1:0]    calc_x, calc_y, dst_y;
    logic [2:0]       calc_p, src_p;
    logic [3:0]       slot_ok, slot_jmp;
    logic [LW-1:0]    slot_dst [4];
    logic [LW-1:0]    slot_mid [4];
    logic [4*SW-1:0]  legal_calc;
    logic             cap_q, chain_q, chain_go;
    logic             own_pick, hit, hit_jmp, promote, reject;
    logic [CNT_W-1:0] opp_cnt;

    function automatic logic [2:0] init_cell(input int i);
        int x, y;
        x = i / N;
        y = i % N;
        init_cell = 3'b000;
        if ((x + y) % 2 == 0) begin
            if (y < INIT_ROWS)
                init_cell = 3'b110;
            else if (y >= N - INIT_ROWS)
                init_cell = 3'b100;
        end
    endfunction

    // One move generator serves the selection in IDLE, the held piece in PICKED and the landed piece in DONE.
    assign calc_loc = (state == S_PICKED) ? src_loc :
                      (state == S_DONE)   ? dst_loc : sel_loc;
    assign {calc_x, calc_y} = calc_loc;
    assign calc_p   = board[calc_loc];
    assign src_p    = board[src_loc];
    assign dst_y    = dst_loc[CW-1:0];
    assign own_pick = calc_p[2] && (calc_p[1] == turn_red);
    assign promote  = src_p[1] ? (dst_y == Y_TOP) : (dst_y == '0);
    assign opp_cnt  = turn_red ? white_cnt : red_cnt;

    for (genvar s = 0; s < 4; s++) begin : g_slot
        localparam bit XP = (s % 2) == 1;
        localparam bit YP = s < 2;
        logic [CW:0]   ax, ay, bx, by;
        logic [LW-1:0] adj_loc, far_loc;
        logic          adj_in, far_in, adj_occ, adj_red, far_occ, dir_ok, step, jump;

        assign ax      = XP ? {1'b0, calc_x} + ONE : {1'b0, calc_x} - ONE;
        assign ay      = YP ? {1'b0, calc_y} + ONE : {1'b0, calc_y} - ONE;
        assign bx      = XP ? ax + ONE : ax - ONE;
        assign by      = YP ? ay + ONE : ay - ONE;
        assign adj_loc = {ax[CW-1:0], ay[CW-1:0]};
        assign far_loc = {bx[CW-1:0], by[CW-1:0]};
        assign adj_in  = !ax[CW] && !ay[CW];
        assign far_in  = !bx[CW] && !by[CW];
        assign adj_occ = board[adj_loc][2];
        assign adj_red = board[adj_loc][1];
        assign far_occ = board[far_loc][2];
        assign dir_ok  = calc_p[0] || (calc_p[1] == YP);
        assign step    = adj_in && !adj_occ;
        assign jump    = adj_in && adj_occ && (adj_red != calc_p[1]) && far_in && !far_occ;

        assign slot_ok[s]  = calc_p[2] && dir_ok && (step || jump);
        assign slot_jmp[s] = jump;
        assign slot_dst[s] = step ? adj_loc : far_loc;
        assign slot_mid[s] = adj_loc;
        assign legal_calc[s*SW +: SW] = slot_ok[s] ? {1'b1, slot_dst[s]} : '0;
    end

`ifdef CHECKERS_MULTI_JUMP_EN
    logic promo_q;
    assign chain_go = cap_q && !promo_q && (|(slot_ok & slot_jmp));
`else
    assign chain_go = 1'b0;
`endif

    always_comb begin
        hit     = 1'b0;
        hit_jmp = 1'b0;
        hit_mid = '0;
        for (int s = 0; s < 4; s++) begin
            if (slot_ok[s] && (slot_dst[s] == sel_loc) && (!chain_q || slot_jmp[s])) begin
                hit     = 1'b1;
                hit_jmp = slot_jmp[s];
                hit_mid = slot_mid[s];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        reject   = 1'b0;
        case (state)
            S_IDLE: begin
                if (sel_valid) begin
                    if (own_pick)
                        state_nx = S_PICKED;
                    else
                        reject = 1'b1;
                end
            end
            S_PICKED: begin
                if (sel_valid) begin
                    if ((sel_loc == src_loc) && !chain_q)
                        state_nx = S_IDLE;
                    else if (hit)
                        state_nx = S_WR_DST;
                    else
                        reject = 1'b1;
                end
            end
            S_WR_DST:  state_nx = S_CLR_CAP;
            S_CLR_CAP: state_nx = S_CLR_SRC;
            S_CLR_SRC: state_nx = S_DONE;
            S_DONE: begin
                if (opp_cnt == '0)
                    state_nx = S_OVER;
                else if (chain_go)
                    state_nx = S_PICKED;
                else
                    state_nx = S_IDLE;
            end
            S_OVER:  state_nx = S_OVER;
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy      = (state == S_WR_DST) || (state == S_CLR_CAP) ||
                       (state == S_CLR_SRC) || (state == S_DONE);
    assign move_done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NC; i++)
                board[i] <= init_cell(i);
            src_loc     <= '0;
            dst_loc     <= '0;
            mid_loc     <= '0;
            cap_q       <= 1'b0;
            chain_q     <= 1'b0;
            turn_red    <= 1'b1;
            red_cnt     <= INIT_CNT;
            white_cnt   <= INIT_CNT;
            legal_move  <= '0;
            move_reject <= 1'b0;
            game_over   <= 1'b0;
            winner_red  <= 1'b0;
`ifdef CHECKERS_MULTI_JUMP_EN
            promo_q     <= 1'b0;
`endif
        end else begin
            move_reject <= reject;
            legal_move  <= ((state == S_IDLE) || (state == S_PICKED)) ? legal_calc : '0;
            case (state)
                S_IDLE: begin
                    if (sel_valid && own_pick)
                        src_loc <= sel_loc;
                end
                S_PICKED: begin
                    if (sel_valid && hit && !((sel_loc == src_loc) && !chain_q)) begin
                        dst_loc <= sel_loc;
                        mid_loc <= hit_mid;
                        cap_q   <= hit_jmp;
                    end
                end
                S_WR_DST: begin
                    board[dst_loc] <= {src_p[2:1], src_p[0] | promote};
`ifdef CHECKERS_MULTI_JUMP_EN
                    promo_q <= promote;
`endif
                end
                S_CLR_CAP: begin
                    if (cap_q) begin
                        board[mid_loc] <= 3'b000;
                        if (turn_red)
                            white_cnt <= white_cnt - 1'b1;
                        else
                            red_cnt <= red_cnt - 1'b1;
                    end
                end
                S_CLR_SRC: board[src_loc] <= 3'b000;
                S_DONE: begin
                    if ((opp_cnt != '0) && chain_go) begin
                        src_loc <= dst_loc;
                        chain_q <= 1'b1;
                    end else begin
                        turn_red <= ~turn_red;
                        chain_q  <= 1'b0;
                    end
                    if (opp_cnt == '0) begin
                        game_over  <= 1'b1;
                        winner_red <= turn_red;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        serialized_board = '0;
        for (int i = 0; i < NC; i++)
            serialized_board[3*i +: 3] = board[i];
    end
endmodule

// File: tb/tb_checkers_move_engine.sv
// Directed bench for checkers_move_engine: an 8x8 instance (a) and a 4x4, one-row instance (b).
module tb_checkers_move_engine;
    logic clk = 1'b0;
    logic rst;
    logic sv_a, sv_b;
    logic [5:0]   loc_a;
    logic [3:0]   loc_b;
    logic [191:0] brd_a;
    logic [47:0]  brd_b;
    logic [27:0]  lm_a;
    logic [19:0]  lm_b;
    logic turn_a, busy_a, done_a, rej_a, go_a, win_a;
    logic turn_b, busy_b, done_b, rej_b, go_b, win_b;
    logic [5:0] rc_a, wc_a, rc_b, wc_b;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    checkers_move_engine #(.CW(3), .INIT_ROWS(3), .CNT_W(6)) u_dut_a (
        .clk(clk), .rst(rst), .sel_valid(sv_a), .sel_loc(loc_a),
        .serialized_board(brd_a), .legal_move(lm_a), .turn_red(turn_a),
        .busy(busy_a), .move_done(done_a), .move_reject(rej_a),
        .red_cnt(rc_a), .white_cnt(wc_a), .game_over(go_a), .winner_red(win_a)
    );

    checkers_move_engine #(.CW(2), .INIT_ROWS(1), .CNT_W(6)) u_dut_b (
        .clk(clk), .rst(rst), .sel_valid(sv_b), .sel_loc(loc_b),
        .serialized_board(brd_b), .legal_move(lm_b), .turn_red(turn_b),
        .busy(busy_b), .move_done(done_b), .move_reject(rej_b),
        .red_cnt(rc_b), .white_cnt(wc_b), .game_over(go_b), .winner_red(win_b)
    );

    task automatic check_val(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] cell_a(input int x, input int y);
        return brd_a[3*(x*8+y) +: 3];
    endfunction

    function automatic logic [2:0] cell_b(input int x, input int y);
        return brd_b[3*(x*4+y) +: 3];
    endfunction

    function automatic logic [191:0] layout_a();
        logic [191:0] v;
        v = '0;
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                if ((x + y) % 2 == 0) begin
                    if (y < 3)       v[3*(x*8+y) +: 3] = 3'b110;
                    else if (y >= 5) v[3*(x*8+y) +: 3] = 3'b100;
                end
        return v;
    endfunction

    task automatic sel(input int w, input int x, input int y);
        @(negedge clk);
        if (w == 0) begin
            sv_a  = 1'b1;
            loc_a = {3'(x), 3'(y)};
        end else begin
            sv_b  = 1'b1;
            loc_b = {2'(x), 2'(y)};
        end
        @(negedge clk);
        sv_a = 1'b0;
        sv_b = 1'b0;
    endtask

    // Drop on (x,y) and measure cycles from the accepting edge until move_done.
    task automatic drop(input int w, input int x, input int y, input string tag);
        int n;
        logic md;
        sel(w, x, y);
        n  = 0;
        md = (w == 0) ? done_a : done_b;
        while (!md && n < 10) begin
            @(negedge clk);
            n++;
            md = (w == 0) ? done_a : done_b;
        end
        check_val(tag, 192'(n), 192'(3));
        @(negedge clk);
    endtask

    task automatic mv(input int w, input int sx, input int sy, input int dx, input int dy, input string tag);
        sel(w, sx, sy);
        drop(w, dx, dy, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [47:0] fin_b;
        rst   = 1'b0;
        sv_a  = 1'b0;
        sv_b  = 1'b0;
        loc_a = '0;
        loc_b = '0;
        repeat (3) @(negedge clk);

        check_val("rst_red_cnt",   rc_a, 12);
        check_val("rst_white_cnt", wc_a, 12);
        check_val("rst_turn",      turn_a, 1);
        check_val("rst_cell_1_1",  cell_a(1,1), 3'b110);
        check_val("rst_cell_1_5",  cell_a(1,5), 3'b100);
        check_val("rst_cell_1_0",  cell_a(1,0), 3'b000);
        check_val("rst_layout",    brd_a, layout_a());
        check_val("rst_outs",      {lm_a, busy_a, done_a, rej_a, go_a, win_a}, '0);
        check_val("rst_b_cnts",    {rc_b, wc_b}, {6'd2, 6'd2});

        rst   = 1'b1;
        loc_a = {3'd2, 3'd2};
        @(negedge clk);
        check_val("legal_idle_2_2", lm_a, {7'd0, 7'd0, 7'b1_011_011, 7'b1_001_011});

        sel(0, 1, 5);
        check_val("rej_opponent", rej_a, 1);
        @(negedge clk);
        check_val("rej_pulse_end", rej_a, 0);
        sel(0, 2, 2);
        check_val("pick_no_rej", {rej_a, busy_a}, 2'b00);
        sel(0, 2, 3);
        check_val("rej_bad_dst", rej_a, 1);
        sel(0, 2, 2);
        check_val("deselect_no_rej", rej_a, 0);

        mv(0, 2, 2, 3, 3, "step_lat");
        check_val("step_cell_3_3", cell_a(3,3), 3'b110);
        check_val("step_cell_2_2", cell_a(2,2), 3'b000);
        check_val("step_turn",     turn_a, 0);

        mv(0, 5, 5, 4, 4, "white_lat");
        check_val("white_cell_4_4", cell_a(4,4), 3'b100);
        sel(0, 3, 3);
        check_val("legal_picked_3_3", lm_a, {7'd0, 7'd0, 7'b1_101_101, 7'b1_010_100});
        drop(0, 5, 5, "cap_lat");
        check_val("cap_cell_4_4", cell_a(4,4), 3'b000);
        check_val("cap_cell_5_5", cell_a(5,5), 3'b110);
        check_val("cap_cell_3_3", cell_a(3,3), 3'b000);
        check_val("cap_cnts",     {rc_a, wc_a}, {6'd12, 6'd11});
        check_val("cap_turn",     turn_a, 0);

        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        mv(0, 2, 2, 3, 3, "re_step_lat");
        mv(0, 5, 5, 4, 4, "re_white_lat");
        sel(0, 3, 3);
        sel(0, 5, 5);
        @(negedge clk);
        check_val("busy_in_cap", busy_a, 1);
        rst = 1'b0;
        #1;
        check_val("midrst_busy",   busy_a, 0);
        check_val("midrst_layout", brd_a, layout_a());
        check_val("midrst_cnts",   {rc_a, wc_a, turn_a}, {6'd12, 6'd12, 1'b1});
        @(negedge clk);
        rst = 1'b1;

        mv(1, 0, 0, 1, 1, "b_m1_lat");
        mv(1, 3, 3, 2, 2, "b_m2_lat");
        mv(1, 1, 1, 3, 3, "b_m3_lat");
        check_val("b_king_3_3",  cell_b(3,3), 3'b111);
        check_val("b_cap_2_2",   cell_b(2,2), 3'b000);
        check_val("b_white_cnt", wc_b, 1);
        check_val("b_turn",      turn_b, 0);
        mv(1, 1, 3, 0, 2, "b_m4_lat");
        mv(1, 3, 3, 2, 2, "b_king_back_lat");
        mv(1, 0, 2, 1, 1, "b_m6_lat");
        mv(1, 2, 2, 0, 0, "b_final_lat");
        check_val("b_game_over", {go_b, win_b}, 2'b11);
        check_val("b_end_cnts",  {rc_b, wc_b}, {6'd2, 6'd0});
        fin_b = '0;
        fin_b[2:0]   = 3'b111;
        fin_b[26:24] = 3'b110;
        check_val("b_end_board", brd_b, fin_b);

        sel(1, 2, 0);
        check_val("b_over_ignore", {rej_b, busy_b}, 2'b00);
        repeat (2) @(negedge clk);
        check_val("b_over_board", brd_b, fin_b);
        check_val("b_over_sticky", {go_b, win_b, lm_b}, {2'b11, 20'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
